ahb_burst_slave: RTL and testbench

//  AHB-Lite subordinate (responder) backed by a word-organised SRAM. Sits behind the
//  bus decoder and answers the bursts the AHB master issues (SINGLE/INCR/WRAPx/INCRx).

---
 rtl/ahb_burst_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_ahb_burst_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_slave.sv
// ahb_burst_slave: AHB-Lite subordinate over a word-organised SRAM with per-beat burst legality checks.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states ahead of every OKAY data phase.
module ahb_burst_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic [7:0]            err_cnt
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_SEQ  = 2'b11;
  localparam logic [2:0] BU_INCR = 3'd1;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'd0:       burst_len = 5'd1;
      3'd1:       burst_len = 5'd0;
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      default:    burst_len = 5'd16;
    endcase
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    is_wrap = (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
  endfunction

  logic [2:0]            state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [IDX_W+1:0]      addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  trk_act_q, trk_act_d;
  logic [2:0]            trk_burst_q, trk_burst_d;
  logic [2:0]            trk_size_q, trk_size_d;
  logic                  trk_write_q, trk_write_d;
  logic [4:0]            trk_left_q, trk_left_d;
  logic [ADDR_WIDTH-1:0] trk_prev_q, trk_prev_d;

  logic [31:0]           mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]      mem_idx;
  logic                  mem_we;
  logic [3:0]            mem_be;

  logic                  accept;
  logic                  is_seq;
  logic [4:0]            len;
  logic [ADDR_WIDTH-1:0] beat_b;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  size_bad, align_bad, cross_bad;
  logic [4:0]            trk_len;
  logic [ADDR_WIDTH-1:0] trk_b, trk_win, next_inc, exp_addr;
  logic                  seq_orphan, seq_attr, seq_addr;
  logic                  beat_err;

  assign accept = hsel && hready && htrans[1];
  assign is_seq = (htrans == TR_SEQ);

  // Legality of the incoming beat on its own: size, alignment, 1KB span of fixed INCR bursts
  always_comb begin
    len       = burst_len(hburst);
    size_bad  = (hsize > 3'd2);
    beat_b    = ADDR_WIDTH'(1) << hsize[1:0];
    align_bad = ((haddr & (beat_b - ADDR_WIDTH'(1))) != '0);
    last_addr = haddr + ADDR_WIDTH'(len) * beat_b - ADDR_WIDTH'(1);
    cross_bad = !is_seq && hburst[0] && (hburst != BU_INCR) &&
                (haddr[ADDR_WIDTH-1:10] != last_addr[ADDR_WIDTH-1:10]);
  end

  // Legality of a SEQ beat against the burst started by the last accepted NONSEQ
  always_comb begin
    trk_len    = burst_len(trk_burst_q);
    trk_b      = ADDR_WIDTH'(1) << trk_size_q;
    trk_win    = ADDR_WIDTH'(trk_len) * trk_b;
    next_inc   = trk_prev_q + trk_b;
    exp_addr   = next_inc;
    if (is_wrap(trk_burst_q)) begin
      exp_addr = (trk_prev_q & ~(trk_win - ADDR_WIDTH'(1))) |
                 (next_inc & (trk_win - ADDR_WIDTH'(1)));
    end
    seq_orphan = !trk_act_q || ((trk_burst_q != BU_INCR) && (trk_left_q == 5'd0));
    seq_attr   = (hburst != trk_burst_q) || (hsize != trk_size_q) || (hwrite != trk_write_q);
    seq_addr   = (haddr != exp_addr);
    beat_err   = size_bad || align_bad || cross_bad ||
                 (is_seq && (seq_orphan || seq_attr || seq_addr));
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    err_cnt_d   = err_cnt_q;
    trk_act_d   = trk_act_q;
    trk_burst_d = trk_burst_q;
    trk_size_d  = trk_size_q;
    trk_write_d = trk_write_q;
    trk_left_d  = trk_left_q;
    trk_prev_d  = trk_prev_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 3'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 drive hreadyout high, so the next address phase is sampled here
        mem_we  = (state_q == ST_DATA) && write_q;
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = haddr[IDX_W+1:0];
          size_d  = hsize[1:0];
          write_d = hwrite;
          if (beat_err) begin
            state_d   = ST_ERR1;
            trk_act_d = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            wcnt_d = WAIT_LOAD;
`ifdef AHB_SLV_WAIT_EN
            state_d = ST_WAIT;
`else
            state_d = ST_DATA;
`endif
            trk_prev_d = haddr;
            if (is_seq) begin
              if (trk_burst_q != BU_INCR) trk_left_d = trk_left_q - 5'd1;
            end else begin
              trk_act_d   = 1'b1;
              trk_burst_d = hburst;
              trk_size_d  = hsize;
              trk_write_d = hwrite;
              trk_left_d  = len - 5'd1;
            end
          end
        end else if (hsel && hready && (htrans == TR_IDLE)) begin
          trk_act_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 3'd0;
      size_q      <= 2'd0;
      write_q     <= 1'b0;
      err_cnt_q   <= 8'd0;
      trk_act_q   <= 1'b0;
      trk_burst_q <= 3'd0;
      trk_size_q  <= 3'd0;
      trk_write_q <= 1'b0;
      trk_left_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      size_q      <= size_d;
      write_q     <= write_d;
      err_cnt_q   <= err_cnt_d;
      trk_act_q   <= trk_act_d;
      trk_burst_q <= trk_burst_d;
      trk_size_q  <= trk_size_d;
      trk_write_q <= trk_write_d;
      trk_left_q  <= trk_left_d;
    end
  end

  always_ff @(posedge hclk) begin
    addr_q     <= addr_d;
    trk_prev_q <= trk_prev_d;
  end

  assign mem_idx = addr_q[IDX_W+1:2];

  always_comb begin
    mem_be = 4'b1111;
    case (size_q)
      2'd0:    mem_be = 4'b0001 << addr_q[1:0];
      2'd1:    mem_be = 4'b0011 << addr_q[1:0];
      default: mem_be = 4'b1111;
    endcase
  end

  // SRAM contents survive reset; only enabled little-endian lanes are updated
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem_q[mem_idx] : 32'd0;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ahb_burst_slave.sv
// Directed testbench for ahb_burst_slave: pipelined AHB master driving beat tables with hand-computed expectations.
module tb_ahb_burst_slave;
  localparam int AW = 16;
  localparam int WC = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int WEXP = WC;
`else
  localparam int WEXP = 0;
`endif

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic [7:0]    err_cnt;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  ahb_burst_slave #(.ADDR_WIDTH(AW), .MEM_DEPTH(256), .WAIT_CYCLES(WC)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  logic [1:0]    b_trans [8];
  logic [AW-1:0] b_addr  [8];
  logic          b_write [8];
  logic [2:0]    b_size  [8];
  logic [2:0]    b_burst [8];
  logic [31:0]   b_wdata [8];
  logic          r_resp  [8];
  int            r_err1  [8];
  int            r_waits [8];
  logic [31:0]   r_rdata [8];
  int            nb = 0;

  task automatic add(input logic [1:0] tr, input logic [AW-1:0] a, input logic w,
                     input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
    b_trans[nb] = tr; b_addr[nb] = a; b_write[nb] = w;
    b_size[nb] = sz; b_burst[nb] = bu; b_wdata[nb] = wd;
    nb++;
  endtask

  task automatic present(input int k);
    hsel = 1'b1;
    if (k < nb) begin
      htrans = b_trans[k]; haddr = b_addr[k]; hwrite = b_write[k];
      hsize = b_size[k]; hburst = b_burst[k];
    end else begin
      htrans = IDLE;
    end
  endtask

  // Called at posedge+1; drives the table pipelined and returns at posedge+1 with IDLE on the bus.
  task automatic run(input bit abort_on_err);
    int ap, dp, cyc;
    bit rdy, aborted;
    ap = 0; dp = -1; cyc = 0; aborted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r_resp[i] = 1'b0; r_err1[i] = 0; r_waits[i] = 0; r_rdata[i] = 32'd0;
    end
    present(0);
    hwdata = 32'd0;
    while (!(ap >= nb && dp < 0)) begin
      @(negedge hclk);
      rdy = hreadyout;
      if (dp >= 0) begin
        if (!hreadyout && hresp) begin
          r_err1[dp]++;
          if (abort_on_err) aborted = 1'b1;
        end else if (!hreadyout) begin
          r_waits[dp]++;
        end else begin
          r_resp[dp]  = hresp;
          r_rdata[dp] = hrdata;
        end
      end
      @(posedge hclk);
      if (rdy) begin
        dp = (ap < nb) ? ap : -1;
        if (ap < nb) ap++;
      end
      if (aborted) ap = nb;
      #1;
      present(ap);
      hwdata = (dp >= 0) ? b_wdata[dp] : 32'd0;
      cyc++;
      if (cyc > 200) begin
        check("run_timeout", 32'(ap), 32'(nb));
        break;
      end
    end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = IDLE; hwrite = 1'b0;
    hsize = 3'd2; hburst = SINGLE; hwdata = 32'd0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp",     32'(hresp),     32'd0);
    check("rst_hrdata",    hrdata,         32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(posedge hclk); #1 hreset = 1'b0;
    @(posedge hclk); #1;

    // Word write then immediate read of the same word
    nb = 0;
    add(NSEQ, 16'h0040, 1'b1, 3'd2, SINGLE, 32'hA5A5_1234);
    add(NSEQ, 16'h0040, 1'b0, 3'd2, SINGLE, 32'd0);
    run(1'b1);
    check("single_wr_resp",  32'(r_resp[0]),  32'd0);
    check("single_wr_waits", 32'(r_waits[0]), 32'(WEXP));
    check("single_rd_resp",  32'(r_resp[1]),  32'd0);
    check("single_rd_waits", 32'(r_waits[1]), 32'(WEXP));
    check("single_rd_data",  r_rdata[1],      32'hA5A5_1234);
    @(negedge hclk);
    check("idle_hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;

    // INCR4 crossing 1KB: errors, must not overwrite the preloaded word
    nb = 0;
    add(NSEQ, 16'h03F8, 1'b1, 3'd2, SINGLE, 32'h1122_3344);
    run(1'b1);
    nb = 0;
    add(NSEQ, 16'h03F8, 1'b1, 3'd2, INCR4, 32'hDEAD_BEEF);
    add(SEQ,  16'h03FC, 1'b1, 3'd2, INCR4, 32'hDEAD_BEE0);
    run(1'b1);
    check("kb_err1_cycles", 32'(r_err1[0]),  32'd1);
    check("kb_err2_resp",   32'(r_resp[0]),  32'd1);
    check("kb_err_waits",   32'(r_waits[0]), 32'd0);
    check("kb_err_cnt",     32'(err_cnt),    32'd1);
    nb = 0;
    add(NSEQ, 16'h03F8, 1'b0, 3'd2, SINGLE, 32'd0);
    run(1'b1);
    check("kb_no_write", r_rdata[0], 32'h1122_3344);

    // WRAP4 from 0x038 wraps to 0x030; a fifth SEQ is illegal
    nb = 0;
    add(NSEQ, 16'h0038, 1'b1, 3'd2, WRAP4, 32'hC0DE_0038);
    add(SEQ,  16'h003C, 1'b1, 3'd2, WRAP4, 32'hC0DE_003C);
    add(SEQ,  16'h0030, 1'b1, 3'd2, WRAP4, 32'hC0DE_0030);
    add(SEQ,  16'h0034, 1'b1, 3'd2, WRAP4, 32'hC0DE_0034);
    add(SEQ,  16'h0040, 1'b1, 3'd2, WRAP4, 32'hFFFF_FFFF);
    run(1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_resp%0d", i),  32'(r_resp[i]),  32'd0);
      check($sformatf("wrap_waits%0d", i), 32'(r_waits[i]), 32'(WEXP));
    end
    check("wrap_extra_resp", 32'(r_resp[4]), 32'd1);
    check("wrap_err_cnt",    32'(err_cnt),   32'd2);
    nb = 0;
    add(NSEQ, 16'h0030, 1'b0, 3'd2, INCR4, 32'd0);
    add(SEQ,  16'h0034, 1'b0, 3'd2, INCR4, 32'd0);
    add(SEQ,  16'h0038, 1'b0, 3'd2, INCR4, 32'd0);
    add(SEQ,  16'h003C, 1'b0, 3'd2, INCR4, 32'd0);
    run(1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr4_rd%0d", i), r_rdata[i], 32'hC0DE_0030 + 32'(4 * i));
      check($sformatf("incr4_resp%0d", i), 32'(r_resp[i]), 32'd0);
    end

    // Sub-word lanes
    nb = 0;
    add(NSEQ, 16'h0080, 1'b1, 3'd2, SINGLE, 32'h1111_2222);
    add(NSEQ, 16'h0082, 1'b1, 3'd1, SINGLE, 32'hBEEF_0000);
    add(NSEQ, 16'h0080, 1'b0, 3'd2, SINGLE, 32'd0);
    add(NSEQ, 16'h0081, 1'b1, 3'd0, SINGLE, 32'h0000_5A00);
    add(NSEQ, 16'h0080, 1'b0, 3'd2, SINGLE, 32'd0);
    run(1'b1);
    check("half_lane_rd", r_rdata[2], 32'hBEEF_2222);
    check("byte_lane_rd", r_rdata[4], 32'hBEEF_5A22);
    nb = 0;
    add(NSEQ, 16'h0081, 1'b1, 3'd1, SINGLE, 32'h0000_0000);
    run(1'b1);
    check("half_misalign_resp", 32'(r_resp[0]), 32'd1);
    check("half_misalign_cnt",  32'(err_cnt),   32'd3);

    // SEQ sampled during ERR2 is checked fresh
    nb = 0;
    add(NSEQ, 16'h0041, 1'b1, 3'd2, INCR, 32'd0);
    add(SEQ,  16'h0044, 1'b1, 3'd2, INCR, 32'd0);
    run(1'b0);
    check("err2_seq_resp0", 32'(r_resp[0]), 32'd1);
    check("err2_seq_resp1", 32'(r_resp[1]), 32'd1);
    check("err2_seq_err1",  32'(r_err1[1]), 32'd1);
    check("err2_seq_cnt",   32'(err_cnt),   32'd5);

    nb = 0;
    add(NSEQ, 16'h0100, 1'b0, 3'd3, SINGLE, 32'd0);
    run(1'b1);
    check("size3_resp", 32'(r_resp[0]), 32'd1);

    nb = 0;
    add(NSEQ, 16'h0200, 1'b1, 3'd2, INCR, 32'h0000_0200);
    add(SEQ,  16'h0204, 1'b0, 3'd2, INCR, 32'd0);
    run(1'b1);
    check("attr_first_resp", 32'(r_resp[0]), 32'd0);
    check("attr_chg_resp",   32'(r_resp[1]), 32'd1);

    nb = 0;
    add(NSEQ, 16'h0200, 1'b1, 3'd2, INCR, 32'h0000_0200);
    add(SEQ,  16'h0208, 1'b1, 3'd2, INCR, 32'd0);
    run(1'b1);
    check("seq_addr_resp", 32'(r_resp[1]), 32'd1);
    check("seq_addr_cnt",  32'(err_cnt),   32'd8);

    // Upper address bits alias onto the 1KB array
    nb = 0;
    add(NSEQ, 16'h50C0, 1'b1, 3'd2, SINGLE, 32'h0A11_A500);
    add(NSEQ, 16'h00C0, 1'b0, 3'd2, SINGLE, 32'd0);
    run(1'b1);
    check("alias_wr_resp", 32'(r_resp[0]), 32'd0);
    check("alias_rd",      r_rdata[1],     32'h0A11_A500);

    // Drive err_cnt to saturation
    for (int k = 0; k < 248; k++) begin
      nb = 0;
      add(NSEQ, 16'h0041, 1'b1, 3'd2, SINGLE, 32'd0);
      run(1'b1);
      if (k == 246) check("err_cnt_255", 32'(err_cnt), 32'd255);
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset in the middle of an INCR4
    hsel = 1'b1; htrans = NSEQ; haddr = 16'h0100; hwrite = 1'b1; hsize = 3'd2; hburst = INCR4;
    @(posedge hclk); #1;
    htrans = SEQ; haddr = 16'h0104; hwdata = 32'h0BAD_0100;
    @(posedge hclk); #1;
    hreset = 1'b1; hsel = 1'b0; htrans = IDLE;
    @(negedge hclk);
    check("midrst_hreadyout", 32'(hreadyout), 32'd1);
    check("midrst_hresp",     32'(hresp),     32'd0);
    check("midrst_hrdata",    hrdata,         32'd0);
    check("midrst_err_cnt",   32'(err_cnt),   32'd0);
    @(posedge hclk); #1 hreset = 1'b0;
    @(posedge hclk); #1;
    nb = 0;
    add(SEQ, 16'h0108, 1'b1, 3'd2, INCR4, 32'd0);
    run(1'b1);
    check("postrst_seq_resp", 32'(r_resp[0]), 32'd1);
    check("postrst_err_cnt",  32'(err_cnt),   32'd1);
    nb = 0;
    add(NSEQ, 16'h0040, 1'b0, 3'd2, SINGLE, 32'd0);
    run(1'b1);
    check("sram_kept", r_rdata[0], 32'hA5A5_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
